// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the pixel RAM stream reader.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO that absorbs RAM read latency; push and pop may coincide.
module stream_fifo2
    import ram_stream_pkg::*;
#(
    parameter int SIZE = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [SIZE-1:0] push_data,
    input  logic            pop,
    output logic [SIZE-1:0] head,
    output logic [1:0]      count,
    output logic            not_empty
);

    logic [SIZE-1:0] entry_r [FIFO_DEPTH];
    logic            rd_ptr_r;
    logic            wr_ptr_r;
    logic [1:0]      count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    // Qualify requests so a full FIFO only accepts a push alongside a pop.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (push && ((count_r < 2'(FIFO_DEPTH)) || pop)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
        if (pop && (count_r != 2'd0)) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_r  <= '{default: '0};
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                entry_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
        end
    end

    assign head      = entry_r[rd_ptr_r];
    assign count     = count_r;
    assign not_empty = (count_r != 2'd0);

endmodule

// File: rtl/ram_stream_reader.sv
// Walks pixel RAM addresses 0..len-1 and streams each word out on valid/ready,
// hiding the one-cycle RAM read latency behind a two-entry FIFO.
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int SIZE  = 24,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LW-1:0]   length,
    output logic [AW-1:0]   ram_address,
    input  logic [SIZE-1:0] ram_read_data,
    output logic [SIZE-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done
);

    state_t        state_r;
    logic [LW-1:0] len_r;
    logic [LW-1:0] issued_r;
    logic [LW-1:0] accepted_r;
    logic          inflight_r;
    logic [LW-1:0] clamp_len_s;
    logic [LW-1:0] next_issued_s;
    logic [1:0]    fifo_count_s;
    logic          pop_s;
    logic          issue_s;

    assign pop_s         = out_valid & out_ready;
    assign next_issued_s = issued_r + LW'(1);

    // Clamp the requested length so the address never runs off the RAM.
    always_comb begin
        clamp_len_s = length;
        if (length > LW'(DEPTH)) begin
            clamp_len_s = LW'(DEPTH);
        end else begin
            clamp_len_s = length;
        end
    end

    // Issue a read only if the FIFO is guaranteed room when the data lands.
    always_comb begin
        issue_s = 1'b0;
        if ((state_r == STREAM) && (issued_r < len_r) &&
            (({1'b0, fifo_count_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Pass control: counters, address generation and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            len_r       <= '0;
            issued_r    <= '0;
            accepted_r  <= '0;
            inflight_r  <= 1'b0;
            ram_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    inflight_r <= 1'b0;
                    done       <= 1'b0;
                    if (start) begin
                        len_r       <= clamp_len_s;
                        issued_r    <= '0;
                        accepted_r  <= '0;
                        ram_address <= '0;
                        if (clamp_len_s == '0) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= STREAM;
                            busy    <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    inflight_r <= issue_s;
                    if (issue_s) begin
                        issued_r <= next_issued_s;
                        // Hold on the last address rather than stepping past it.
                        if (next_issued_s < len_r) begin
                            ram_address <= ram_address + AW'(1);
                        end
                    end
                    if (pop_s) begin
                        accepted_r <= accepted_r + LW'(1);
                    end
                    if ((accepted_r + LW'(pop_s)) == len_r) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    inflight_r  <= 1'b0;
                    ram_address <= '0;
                end
                default: begin
                    state_r     <= IDLE;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    inflight_r  <= 1'b0;
                    ram_address <= '0;
                end
            endcase
        end
    end

    stream_fifo2 #(
        .SIZE (SIZE)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data (ram_read_data),
        .pop       (pop_s),
        .head      (out_data),
        .count     (fifo_count_s),
        .not_empty (out_valid)
    );

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side engine for the single-port pixel RAM. On `start`, it walks addresses 0..length-1 and absorbs the RAM's one-cycle read latency.
- It presents each word on a valid/ready stream to the APA102 serializer, holding the stream under backpressure without dropping or duplicating words.
- The HDMI capture side owns RAM writes. Port arbitration is external; this block never writes.

Parameters:
- SIZE, 24, bits per RAM entry / stream word.
- DEPTH, 256, RAM entries; AW = $clog2(DEPTH), LW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a pass; sampled only in IDLE.
- length  in  LW  words to stream; latched on accepted start.
- ram_address  out  AW  RAM address; registered.
- ram_read_data  in  SIZE  RAM output; holds mem[address of previous cycle].
- out_data  out  SIZE  stream word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when valid&ready.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset values: ram_address=0, out_valid=0, out_data=0, busy=0, done=0, state=IDLE, FIFO empty, inflight_q=0, counters 0.
- States:
  - IDLE: on start, latch len = min(length, DEPTH), clear the issue/accept counters, go to STREAM. If len==0, go to DONE instead.
  - STREAM: runs until the accept counter reaches len, then goes to DONE.
  - DONE: lasts one cycle, done=1, then returns to IDLE.
- Issuing reads:
  - A read is issued in a cycle when issued<len AND fifo_count + inflight_q < 2 + pop, where pop = out_valid & out_ready. This is combinational on out_ready.
  - On issue: ram_address increments (registered) and inflight_q <= 1; otherwise inflight_q <= 0.
  - ram_address value during the issue cycle is the address read.
- Capture: when inflight_q==1, ram_read_data is pushed into a 2-entry FIFO. Push and pop may occur in the same cycle.
- FIFO occupancy never exceeds 2; overflow is a design error and is flagged by an assertion in the bench.
- Output:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - out_data is stable while out_valid & !out_ready.
- Latency: start sampled in cycle 0 gives address 0 in cycle 1 and the first out_valid in cycle 3.
- Throughput: with out_ready held high, one word per cycle sustained.
- Completion:
  - The last handshake occurs in cycle N; in cycle N+1, state=DONE, done=1, busy=0.
  - ram_address resets to 0 on entry to IDLE.
- Edge cases:
  - start while not IDLE: ignored, no effect on the current pass.
  - length > DEPTH: clamped to DEPTH, so the address never wraps.
  - length==0: done=1 in cycle 1, no out_valid.
- rst mid-pass: next cycle returns to reset values. FIFO and inflight are flushed, no done pulse, and no stale word is emitted after reset.

Decomposition:
- Package ram_stream_pkg holds the state encoding localparams (IDLE, STREAM, DONE) and the FIFO depth constant 2.
- One sub-module: stream_fifo2, a 2-entry FIFO with push/pop/count, same clk/rst, simultaneous push+pop allowed.

Test Plan:
- RAM preloaded mem[i]=i*3, length=8, out_ready=1: first out_valid cycle 3; words 0,3,...,21 on consecutive cycles; done in the cycle after the 8th handshake.
- Same data, out_ready toggles 1,0,0,1 repeating: exactly 8 words, in order, no repeats. out_data held during stalls; FIFO count ≤2 every cycle.
- out_ready=0 for 20 cycles after start, then 1: out_data=0 held; ram_address stops at 2; then 8 words stream back-to-back.
- length=0: done pulses in cycle 1; out_valid and busy never assert.
- length=DEPTH+5, DEPTH=16: exactly 16 words (addresses 0..15); ram_address never wraps past 15 during the pass.
- rst asserted after the 3rd handshake of length=8, with start also pulsed mid-pass beforehand: start is ignored; after rst all outputs return to 0, and no done pulse occurs. A new start with length=2 then yields mem[0], mem[1].
